// File: rtl/maf_pkg.sv
// Shared sizing helpers for the MAF datapath: alignment window, shift width, exponent bias.
package maf_pkg;

    // Product-aligned window width: 3*m + 2 bits.
    function automatic int unsigned win_width(input int unsigned size_mantissa);
        return 3 * size_mantissa + 2;
    endfunction

    // Width of a shift amount that can reach the full window (0..W inclusive).
    function automatic int unsigned sh_width(input int unsigned size_mantissa);
        return $clog2(3 * size_mantissa + 3);
    endfunction

    function automatic int unsigned exp_bias(input int unsigned size_exponent);
        return (2 ** (size_exponent - 1)) - 1;
    endfunction

endpackage

// File: rtl/align_shift_sticky.sv
// Combinational right shift of the W-bit window, with OR of every bit pushed below it.
module align_shift_sticky #(
    parameter int unsigned W   = 74,
    parameter int unsigned SHW = 7
) (
    input  logic [W-1:0]   din,
    input  logic [SHW-1:0] sh,
    output logic [W-1:0]   dout,
    output logic           sticky
);

    logic [2*W-1:0] wide;

    // The lower half catches whatever falls out of the window; sh <= W by construction.
    always_comb begin
        wide   = {din, {W{1'b0}}} >> sh;
        dout   = wide[2*W-1:W];
        sticky = |wide[W-1:0];
    end

endmodule

// File: rtl/addend_align_stage.sv
// Addend alignment stage: exponent difference, shift clamp and result exponent in stage 1,
// barrel shift plus sticky in stage 2, with valid/ready flow control.
module addend_align_stage
    import maf_pkg::*;
#(
    parameter int unsigned size_exponent = 8,
    parameter int unsigned size_mantissa = 24
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [size_exponent:0]                    exp_ab,
    input  logic [size_exponent-1:0]                  exp_c,
    input  logic [size_mantissa-1:0]                  mant_c,
    input  logic                                      sign_c,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [win_width(size_mantissa)-1:0]       aligned_c,
    output logic                                      sticky_c,
    output logic [size_exponent:0]                    exp_res,
    output logic                                      product_gt,
    output logic                                      c_dominant,
    output logic                                      sign_out
);

    localparam int unsigned W   = win_width(size_mantissa);
    localparam int unsigned SHW = sh_width(size_mantissa);
    localparam int unsigned DW  = size_exponent + 3;
    localparam int unsigned RW  = ((DW > SHW + 1) ? DW : SHW + 1) + 1;

    localparam logic signed [RW-1:0] M_PLUS_2 = RW'(size_mantissa + 2);
    localparam logic signed [RW-1:0] W_MAX    = RW'(W);

    logic en1;
    logic en2;

    logic signed [DW-1:0]  diff;
    logic signed [RW-1:0]  raw;
    logic [SHW-1:0]        sh_next;
    logic                  gt_next;
    logic                  cdom_next;
    logic [size_exponent:0] exp_next;

    logic                     s1_valid;
    logic [SHW-1:0]           s1_sh;
    logic [size_exponent:0]   s1_exp;
    logic [size_mantissa-1:0] s1_mant;
    logic                     s1_sign;
    logic                     s1_gt;
    logic                     s1_cdom;

    logic [W-1:0] shifted;
    logic         sticky_next;

    always_comb begin
        en2      = !out_valid || out_ready;
        en1      = !s1_valid || en2;
        in_ready = en1;
    end

    always_comb begin
        diff      = $signed({2'b00, exp_ab}) - $signed({3'b000, exp_c});
        raw       = $signed({{(RW - DW){diff[DW-1]}}, diff}) + M_PLUS_2;
        cdom_next = raw < 0;
        gt_next   = {1'b0, exp_c} < exp_ab;
        exp_next  = gt_next ? exp_ab : {1'b0, exp_c};
        if (cdom_next)
            sh_next = '0;
        else if (raw > W_MAX)
            sh_next = SHW'(W);
        else
            sh_next = raw[SHW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sh    <= '0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_sign  <= 1'b0;
            s1_gt    <= 1'b0;
            s1_cdom  <= 1'b0;
        end else if (en1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sh   <= sh_next;
                s1_exp  <= exp_next;
                s1_mant <= mant_c;
                s1_sign <= sign_c;
                s1_gt   <= gt_next;
                s1_cdom <= cdom_next;
            end
        end
    end

    align_shift_sticky #(
        .W   (W),
        .SHW (SHW)
    ) u_align_shift_sticky (
        .din    ({s1_mant, {(2 * size_mantissa + 2){1'b0}}}),
        .sh     (s1_sh),
        .dout   (shifted),
        .sticky (sticky_next)
    );

    // Payload only loads with a real item so a stalled or idle output never changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            aligned_c  <= '0;
            sticky_c   <= 1'b0;
            exp_res    <= '0;
            product_gt <= 1'b0;
            c_dominant <= 1'b0;
            sign_out   <= 1'b0;
        end else if (en2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                aligned_c  <= shifted;
                sticky_c   <= sticky_next;
                exp_res    <= s1_exp;
                product_gt <= s1_gt;
                c_dominant <= s1_cdom;
                sign_out   <= s1_sign;
            end
        end
    end

endmodule

// File: tb/tb_addend_align_stage.sv
// Randomized bench for addend_align_stage against an arithmetic reference model and a queue.
module tb_addend_align_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  exp_ab;
    logic [7:0]  exp_c;
    logic [23:0] mant_c;
    logic        sign_c;
    logic        out_valid;
    logic        out_ready;
    logic [73:0] aligned_c;
    logic        sticky_c;
    logic [8:0]  exp_res;
    logic        product_gt;
    logic        c_dominant;
    logic        sign_out;

    addend_align_stage #(
        .size_exponent (8),
        .size_mantissa (24)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .exp_ab     (exp_ab),
        .exp_c      (exp_c),
        .mant_c     (mant_c),
        .sign_c     (sign_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .aligned_c  (aligned_c),
        .sticky_c   (sticky_c),
        .exp_res    (exp_res),
        .product_gt (product_gt),
        .c_dominant (c_dominant),
        .sign_out   (sign_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [73:0] al;
        logic        st;
        logic [8:0]  er;
        logic        gt;
        logic        cd;
        logic        sg;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Place C's MSB at window bit (W-1-sh) in a double-width field; whatever lands below the window is sticky.
    function automatic exp_t model(input logic [8:0] eab, input logic [7:0] ec,
                                   input logic [23:0] mc, input logic sc);
        exp_t        r;
        int          raw;
        int          sh;
        logic [147:0] v;
        raw  = int'(eab) - int'(ec) + 26;
        sh   = (raw < 0) ? 0 : ((raw > 74) ? 74 : raw);
        v    = 148'(mc) << (124 - sh);
        r.al = v[147:74];
        r.st = |v[73:0];
        r.gt = int'(eab) > int'(ec);
        r.er = r.gt ? eab : {1'b0, ec};
        r.cd = raw < 0;
        r.sg = sc;
        r.acc = 0;
        return r;
    endfunction

    task automatic step(input logic iv, input logic ordy, input logic [8:0] eab,
                        input logic [7:0] ec, input logic [23:0] mc, input logic sc);
        exp_t e;
        logic want_ov;
        @(posedge clk);
        #1;
        in_valid  = iv;
        out_ready = ordy;
        exp_ab    = eab;
        exp_c     = ec;
        mant_c    = mc;
        sign_c    = sc;
        @(negedge clk);
        check("in_ready", 128'(in_ready), 128'((q.size() < 2) || ordy));
        want_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
        check("out_valid", 128'(out_valid), 128'(want_ov));
        if (want_ov && out_valid) begin
            e = q[0];
            check("aligned_c", 128'(aligned_c), 128'(e.al));
            check("sticky_c", 128'(sticky_c), 128'(e.st));
            check("exp_res", 128'(exp_res), 128'(e.er));
            check("product_gt", 128'(product_gt), 128'(e.gt));
            check("c_dominant", 128'(c_dominant), 128'(e.cd));
            check("sign_out", 128'(sign_out), 128'(e.sg));
        end
        if (out_valid && ordy && q.size() > 0) void'(q.pop_front());
        if (iv && in_ready) begin
            e = model(eab, ec, mc, sc);
            e.acc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, '0, '0, '0, 1'b0);
    endtask

    task automatic apply_reset(input int n);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        q.delete();
        check("rst out_valid", 128'(out_valid), 128'(0));
        check("rst aligned_c", 128'(aligned_c), 128'(0));
        check("rst flags", 128'({sticky_c, product_gt, c_dominant, sign_out}), 128'(0));
        check("rst exp_res", 128'(exp_res), 128'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        logic [8:0]  r_eab;
        logic [7:0]  r_ec;
        logic [23:0] r_mc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp_ab    = '0;
        exp_c     = '0;
        mant_c    = '0;
        sign_c    = 1'b0;
        apply_reset(3);

        // Directed corner vectors, one per cycle with free-flowing output.
        step(1'b1, 1'b1, 9'd127, 8'd127, 24'h800000, 1'b0);
        step(1'b1, 1'b1, 9'd100, 8'd200, 24'hABCDEF, 1'b1);
        step(1'b1, 1'b1, 9'd300, 8'd10,  24'hC00001, 1'b0);
        step(1'b1, 1'b1, 9'd150, 8'd127, 24'hFFFFFF, 1'b1);
        step(1'b1, 1'b1, 9'd200, 8'd50,  24'h000000, 1'b0);
        step(1'b1, 1'b1, 9'd176, 8'd100, 24'h000001, 1'b0);
        step(1'b1, 1'b1, 9'd48,  8'd100, 24'h123457, 1'b1);
        step(1'b1, 1'b1, 9'd47,  8'd100, 24'h123457, 1'b1);
        idle(4);

        // Backpressure: three back-to-back offers with the output stalled, then release.
        step(1'b1, 1'b0, 9'd130, 8'd120, 24'h9ABCDE, 1'b0);
        step(1'b1, 1'b0, 9'd140, 8'd120, 24'h876543, 1'b1);
        step(1'b1, 1'b0, 9'd160, 8'd120, 24'hFEDCBA, 1'b0);
        step(1'b1, 1'b0, 9'd160, 8'd120, 24'hFEDCBA, 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0);
        idle(5);

        // Reset with both stages full; nothing stale may appear afterwards.
        step(1'b1, 1'b0, 9'd200, 8'd180, 24'hFFFF00, 1'b1);
        step(1'b1, 1'b0, 9'd210, 8'd180, 24'hF0F0F0, 1'b1);
        apply_reset(1);
        idle(4);

        for (int i = 0; i < 800; i++) begin
            r_ec = 8'($urandom_range(0, 255));
            case ($urandom % 4)
                0: r_eab = 9'($urandom_range(0, 511));
                1: r_eab = {1'b0, r_ec};
                2: r_eab = 9'(int'(r_ec) + $urandom_range(0, 90));
                default: r_eab = 9'($urandom_range(0, 255));
            endcase
            r_mc = ($urandom % 8 == 0) ? 24'h0 : 24'($urandom);
            step(($urandom % 4) != 0, ($urandom % 3) != 0, r_eab, r_ec, r_mc, 1'($urandom));
            if (i == 400) apply_reset(2);
        end
        idle(6);
        check("queue drained", 128'(q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
